// File: rtl/digit_entry_encoder.sv
// rtl/digit_entry_encoder.sv - debounced push-button that latches a hex digit as a 7-segment code and strobes a shift
module digit_entry_encoder #(
    parameter int unsigned DB_COUNT = 250000
) (
    input  logic       clock,
    input  logic       En,
    input  logic       btn_n,
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out,
    output logic       shift_pulse,
    output logic [2:0] digit_count,
    output logic       full
);
    localparam int unsigned CW = 20;
    localparam logic [CW-1:0] LAST = CW'(DB_COUNT - 1);
    localparam logic [2:0] MAX_DIGITS = 3'd6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic          sync1;
    logic          btn_s;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          cnt_done;
    logic          accept;
    logic [6:0]    seg_nx;
    logic [2:0]    count_nx;
    logic          full_nx;

    function automatic logic [6:0] encode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Synchronizer resets to 1 so a button held through reset is seen as a fresh press.
    always_ff @(posedge clock or negedge En) begin
        if (!En) begin
            sync1 <= 1'b1;
            btn_s <= 1'b1;
        end else begin
            sync1 <= btn_n;
            btn_s <= sync1;
        end
    end

    always_ff @(posedge clock or negedge En) begin
        if (!En) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign cnt_done = (cnt == LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_nx = DB_PRESS;
                    cnt_nx   = '0;
                end
            end
            DB_PRESS: begin
                if (btn_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt_done) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_nx = DB_RELEASE;
                    cnt_nx   = '0;
                end
            end
            DB_RELEASE: begin
                if (!btn_s) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt_done) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // A press is accepted only on the qualifying DB_PRESS->HELD edge and only while not full.
    always_comb begin
        accept   = (state == DB_PRESS) && !btn_s && cnt_done && !full;
        seg_nx   = accept ? encode(hex_in) : seg_out;
        count_nx = accept ? digit_count + 3'd1 : digit_count;
        full_nx  = (count_nx == MAX_DIGITS);
    end

    always_ff @(posedge clock or negedge En) begin
        if (!En) begin
            seg_out     <= 7'b1111111;
            shift_pulse <= 1'b0;
            digit_count <= 3'd0;
            full        <= 1'b0;
        end else begin
            seg_out     <= seg_nx;
            shift_pulse <= accept;
            digit_count <= count_nx;
            full        <= full_nx;
        end
    end
endmodule

// File: tb/tb_digit_entry_encoder.sv
// tb/tb_digit_entry_encoder.sv - table-driven bench for digit_entry_encoder with DB_COUNT=4
module tb_digit_entry_encoder;
    localparam int DBC = 4;

    logic       clock = 1'b0;
    logic       En = 1'b0;
    logic       btn_n = 1'b1;
    logic [3:0] hex_in = 4'h0;
    logic [6:0] seg_out;
    logic       shift_pulse;
    logic [2:0] digit_count;
    logic       full;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    logic prev_pulse = 1'b0;

    digit_entry_encoder #(.DB_COUNT(DBC)) dut (
        .clock      (clock),
        .En         (En),
        .btn_n      (btn_n),
        .hex_in     (hex_in),
        .seg_out    (seg_out),
        .shift_pulse(shift_pulse),
        .digit_count(digit_count),
        .full       (full)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (shift_pulse === 1'b1) pulses++;
        vectors++;
        if (shift_pulse === 1'b1 && prev_pulse === 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_pulse: shift_pulse high two cycles in a row");
        end
        prev_pulse = shift_pulse;
    end

    typedef struct {
        bit         rst;
        logic [3:0] hex;
        int         exp_pulses;
        logic [6:0] exp_seg;
        int         exp_count;
        bit         exp_full;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        En = 1'b0;
        cyc(2);
        En = 1'b1;
        cyc(1);
    endtask

    task automatic press(input logic [3:0] h);
        hex_in = h;
        @(negedge clock);
        btn_n = 1'b0;
        cyc(20);
        btn_n = 1'b1;
        cyc(20);
    endtask

    initial begin
        int lat;
        tbl[0]  = '{1'b1, 4'h1, 1, 7'b1111001, 1, 1'b0};
        tbl[1]  = '{1'b0, 4'h2, 1, 7'b0100100, 2, 1'b0};
        tbl[2]  = '{1'b0, 4'h3, 1, 7'b0110000, 3, 1'b0};
        tbl[3]  = '{1'b0, 4'h4, 1, 7'b0011001, 4, 1'b0};
        tbl[4]  = '{1'b0, 4'h5, 1, 7'b0010010, 5, 1'b0};
        tbl[5]  = '{1'b0, 4'h6, 1, 7'b0000010, 6, 1'b1};
        tbl[6]  = '{1'b0, 4'h0, 0, 7'b0000010, 6, 1'b1};
        tbl[7]  = '{1'b1, 4'h0, 1, 7'b1000000, 1, 1'b0};
        tbl[8]  = '{1'b0, 4'h7, 1, 7'b1111000, 2, 1'b0};
        tbl[9]  = '{1'b0, 4'h8, 1, 7'b0000000, 3, 1'b0};
        tbl[10] = '{1'b0, 4'h9, 1, 7'b0010000, 4, 1'b0};
        tbl[11] = '{1'b0, 4'hA, 1, 7'b0001000, 5, 1'b0};
        tbl[12] = '{1'b0, 4'hB, 1, 7'b0000011, 6, 1'b1};
        tbl[13] = '{1'b1, 4'hC, 1, 7'b1000110, 1, 1'b0};
        tbl[14] = '{1'b0, 4'hD, 1, 7'b0100001, 2, 1'b0};
        tbl[15] = '{1'b0, 4'hE, 1, 7'b0000110, 3, 1'b0};
        tbl[16] = '{1'b0, 4'hF, 1, 7'b0001110, 4, 1'b0};

        // Reset held with button low: outputs stay at reset values throughout.
        btn_n = 1'b0;
        hex_in = 4'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_seg", 32'(seg_out), 32'h7f);
            check("rst_pulse", 32'(shift_pulse), 0);
            check("rst_count", 32'(digit_count), 0);
            check("rst_full", 32'(full), 0);
        end
        pulses = 0;
        En = 1'b1;
        cyc(20);
        check("rst_release_pulses", 32'(pulses), 1);
        check("rst_release_seg", 32'(seg_out), 32'(7'b0011001));
        check("rst_release_count", 32'(digit_count), 1);
        btn_n = 1'b1;
        cyc(20);

        for (int v = 0; v < 17; v++) begin
            if (tbl[v].rst) do_reset();
            pulses = 0;
            press(tbl[v].hex);
            check($sformatf("tbl%0d_pulses", v), 32'(pulses), 32'(tbl[v].exp_pulses));
            check($sformatf("tbl%0d_seg", v), 32'(seg_out), 32'(tbl[v].exp_seg));
            check($sformatf("tbl%0d_count", v), 32'(digit_count), 32'(tbl[v].exp_count));
            check($sformatf("tbl%0d_full", v), 32'(full), 32'(tbl[v].exp_full));
        end

        // Latency from a clean falling edge to the strobe.
        do_reset();
        pulses = 0;
        hex_in = 4'h3;
        @(negedge clock);
        btn_n = 1'b0;
        lat = 0;
        while (shift_pulse !== 1'b1 && lat < 30) begin
            @(negedge clock);
            lat++;
        end
        check("latency_in_window", 32'(lat >= 5 && lat <= 7), 1);
        cyc(14);
        btn_n = 1'b1;
        cyc(20);
        check("latency_pulses", 32'(pulses), 1);
        check("latency_seg", 32'(seg_out), 32'(7'b0110000));
        check("latency_count", 32'(digit_count), 1);

        // Bounce on the press edge is rejected; only the long low is accepted.
        pulses = 0;
        hex_in = 4'hA;
        @(negedge clock);
        btn_n = 1'b0; cyc(2);
        btn_n = 1'b1; cyc(1);
        btn_n = 1'b0; cyc(2);
        btn_n = 1'b1; cyc(1);
        btn_n = 1'b0; cyc(12);
        btn_n = 1'b1; cyc(20);
        check("bounce_pulses", 32'(pulses), 1);
        check("bounce_seg", 32'(seg_out), 32'(7'b0001000));
        check("bounce_count", 32'(digit_count), 2);

        // hex_in changes while held must not disturb seg_out.
        pulses = 0;
        hex_in = 4'h5;
        @(negedge clock);
        btn_n = 1'b0;
        cyc(10);
        hex_in = 4'h7;
        cyc(90);
        check("hold_pulses", 32'(pulses), 1);
        check("hold_seg", 32'(seg_out), 32'(7'b0010010));
        btn_n = 1'b1;
        cyc(20);
        check("idle_seg", 32'(seg_out), 32'(7'b0010010));

        // Reset mid-debounce discards the press.
        do_reset();
        pulses = 0;
        hex_in = 4'h9;
        @(negedge clock);
        btn_n = 1'b0;
        cyc(5);
        En = 1'b0;
        btn_n = 1'b1;
        cyc(2);
        En = 1'b1;
        cyc(20);
        check("middb_pulses", 32'(pulses), 0);
        check("middb_count", 32'(digit_count), 0);
        check("middb_seg", 32'(seg_out), 32'h7f);
        press(4'h9);
        check("after_middb_pulses", 32'(pulses), 1);
        check("after_middb_seg", 32'(seg_out), 32'(7'b0010000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
